hacd_axi_rd_arbiter: RTL and testbench
======================================

// Module: hacd_axi_rd_arbiter
// PURPOSE
//  - Shares one AXI4 read master port (AR/R) between S_COUNT HACD-side requesters ahead of the crossbar slave port.
//  - Round-robin AR arbitration with per-source outstanding-burst credits.
//  - Tags each issued ARID with the source index and routes R beats back by that tag.
//  - Sits between the HAWK engines / CPU read path and one crossbar s_axi read port.
// PARAMETERS
//  S_COUNT         2                          number of requesters (>=2)
//  ADDR_WIDTH      `HACD_AXI4_ADDR_WIDTH      address width
//  DATA_WIDTH      `HACD_AXI4_DATA_WIDTH      read data width
//  S_ID_WIDTH      4                          requester ID width
//  M_ID_WIDTH      S_ID_WIDTH+$clog2(S_COUNT) issued ID width; source index in the MSBs
//  MAX_OUTSTANDING 8                          per-source cap on in-flight bursts (>=1)
// PORTS
//  clk           in   1                  clock
//  rst_n         in   1                  async active-low reset
//  s_arid        in   S_COUNT*S_ID_WIDTH requester ARID
//  s_araddr      in   S_COUNT*ADDR_WIDTH requester ARADDR
//  s_arlen       in   S_COUNT*8          requester ARLEN
//  s_arsize      in   S_COUNT*3          requester ARSIZE
//  s_arburst     in   S_COUNT*2          requester ARBURST
//  s_arqos       in   S_COUNT*4          requester ARQOS
//  s_arvalid     in   S_COUNT            AR valid
//  s_arready     out  S_COUNT            AR ready
//  s_rid         out  S_COUNT*S_ID_WIDTH routed RID (tag stripped)
//  s_rdata       out  S_COUNT*DATA_WIDTH routed RDATA
//  s_rresp       out  S_COUNT*2          routed RRESP
//  s_rlast       out  S_COUNT            routed RLAST
//  s_rvalid      out  S_COUNT            routed RVALID
//  s_rready      in   S_COUNT            requester RREADY
//  m_arid/araddr/arlen/arsize/arburst/arqos  out  per above widths  issued AR payload
//  m_arvalid     out  1                  issued AR valid
//  m_arready     in   1                  issued AR ready
//  m_rid         in   M_ID_WIDTH         returned RID
//  m_rdata       in   DATA_WIDTH         returned RDATA
//  m_rresp       in   2                  returned RRESP
//  m_rlast       in   1                  returned RLAST
//  m_rvalid      in   1                  returned RVALID
//  m_rready      out  1                  returned RREADY
//  err_bad_rid   out  1                  sticky: R beat arrived with out-of-range source tag
// BEHAVIOUR
//  - Reset:
//    - m_arvalid=0, s_arready=0, all credit counters=0, rr pointer=0 (source 0 favoured first), err_bad_rid=0.
//    - m_ar* payload registers reset to 0.
//  - AR output is a single register stage. States are EMPTY and FULL, with FULL <=> m_arvalid=1.
//  - Eligibility: a source is eligible iff s_arvalid[i] and credit[i] < MAX_OUTSTANDING.
//  - Load condition: load = EMPTY or (FULL and m_arready).
//  - Grant: on load, the first eligible source at or after the rr pointer is granted.
//    - s_arready[grant]=1 in the same cycle; all other s_arready bits are 0.
//    - The payload is registered and m_arid={src_idx, s_arid} from the next cycle.
//    - rr pointer advances to grant+1 (mod S_COUNT).
//  - Latency and throughput: s_arvalid to m_arvalid is 1 cycle. Throughput is 1 AR per cycle with no bubble under back-to-back accept.
//  - Held AR: while FULL and !m_arready, m_ar* is stable and no s_arready is asserted (AXI rule: valid never drops).
//  - Credits:
//    - credit[i]++ on s_arvalid[i]&&s_arready[i].
//    - credit[i]-- on m_rvalid&&m_rready&&m_rlast with tag==i.
//    - If both happen in the same cycle, the count is unchanged.
//    - The counter saturates neither way; overflow and underflow are assertion failures in simulation.
//  - R routing is combinational, with no added latency:
//    - idx = m_rid[M_ID_WIDTH-1 -: $clog2(S_COUNT)].
//    - s_rvalid[idx]=m_rvalid, m_rready=s_rready[idx].
//    - s_rid[idx]=m_rid[S_ID_WIDTH-1:0]. Data, resp and last are broadcast to all sources.
//  - idx >= S_COUNT (S_COUNT not a power of 2): m_rready=1, beat dropped, err_bad_rid set until reset.
//  - Reset mid-burst: the outstanding state is discarded. The downstream side must be reset in the same domain.
// CONFIGURATION
//  - HACD_RD_ARB_QOS_EN defined:
//    - The grant goes to the eligible source with the highest s_arqos.
//    - Ties are broken round-robin from the rr pointer.
//    - The rr pointer advances only past the granted source.
//  - Undefined: pure round-robin and s_arqos is ignored for arbitration. m_arqos still forwards the granted source's value.
// STRUCTURE
//  - hacd_pkg: localparam SRC_IDX_W=$clog2(S_COUNT) helper, and a typedef for the packed AR payload struct.
//  - One sub-module: hacd_rr_arbiter (S_COUNT-wide request/grant).
//    - Inputs: req, optional prio vector.
//    - Outputs: one-hot grant plus an index.
//    - The pointer is updated on an advance strobe.
// TESTING
//  - Single source 0: arid=3, arlen=3, m_arready=1.
//    - m_arvalid is seen 1 cycle after s_arvalid, with m_arid={1'b0,4'h3}.
//    - The R beat with rid=5'h03 returns on s_rvalid[0] with s_rid=3.
//    - credit[0] goes 1 then 0 after rlast.
//  - Both sources continuously valid, m_arready=1: grants alternate 0,1,0,1 and there are no idle cycles on m_arvalid.
//  - m_arready held low 5 cycles: m_ar* is stable and s_arready=0 throughout. On release the next grant follows with no bubble.
//  - Credit cap, MAX_OUTSTANDING=8 and no R traffic:
//    - Source 0 gets 8 accepts, then s_arready[0] stays 0 while source 1 is still granted.
//    - One rlast to source 0 re-enables it the next cycle.
//  - Same-cycle AR accept and rlast for source 1 with credit=4: credit stays 4.
//  - QOS_EN: src0 qos=2 and src1 qos=9 both valid gives three consecutive grants to src1. Equal qos alternates.

Source files
------------

// File: rtl/hacd_pkg.sv
// Shared helpers for the HACD AXI read arbiter: source-index width and the AR control payload.
package hacd_pkg;

  localparam int unsigned DefSCount = 2;
  localparam int unsigned SRC_IDX_W = $clog2(DefSCount);

  // A single source still needs a one-bit index field.
  function automatic int unsigned src_idx_w(input int unsigned s_count);
    return (s_count > 1) ? $clog2(s_count) : 1;
  endfunction

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [3:0] qos;
  } ar_ctrl_t;

endpackage

// File: rtl/hacd_rr_arbiter.sv
// N-way round-robin arbiter with a registered pointer; HACD_RD_ARB_QOS_EN restricts the
// candidates to the highest-priority requesters before the round-robin pick.
module hacd_rr_arbiter
  import hacd_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned PrioW = 4,
  localparam int unsigned IdxW = src_idx_w(N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N-1:0]      req_i,
  input  logic [N*PrioW-1:0] prio_i,
  input  logic              advance_i,
  output logic [N-1:0]      gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    cand;

`ifdef HACD_RD_ARB_QOS_EN
  logic [PrioW-1:0] top_prio;

  always_comb begin
    top_prio = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && (prio_i[i*PrioW +: PrioW] > top_prio)) begin
        top_prio = prio_i[i*PrioW +: PrioW];
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      cand[i] = req_i[i] && (prio_i[i*PrioW +: PrioW] == top_prio);
    end
  end
`else
  logic unused_prio;
  assign unused_prio = ^prio_i;
  assign cand        = req_i;
`endif

  // Scan from the pointer; the first candidate found wins.
  always_comb begin
    logic [IdxW-1:0] pos;
    logic            found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IdxW'((32'(ptr_q) + k) % N);
      if (!found && cand[pos]) begin
        found      = 1'b1;
        idx_o      = pos;
        gnt_o[pos] = 1'b1;
      end
    end
    valid_o = found;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && valid_o) begin
      ptr_d = (idx_o == IdxW'(N - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hacd_axi_rd_arbiter.sv
// Shares one AXI4 read master between S_COUNT requesters: registered AR stage, source-tagged
// ARID, per-source burst credits, combinational R routing. Option: HACD_RD_ARB_QOS_EN.
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 32
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif

module hacd_axi_rd_arbiter
  import hacd_pkg::*;
#(
  parameter int unsigned S_COUNT         = 2,
  parameter int unsigned ADDR_WIDTH      = `HACD_AXI4_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = `HACD_AXI4_DATA_WIDTH,
  parameter int unsigned S_ID_WIDTH      = 4,
  parameter int unsigned M_ID_WIDTH      = S_ID_WIDTH + $clog2(S_COUNT),
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*S_ID_WIDTH-1:0] s_arid,
  input  logic [S_COUNT*ADDR_WIDTH-1:0] s_araddr,
  input  logic [S_COUNT*8-1:0]          s_arlen,
  input  logic [S_COUNT*3-1:0]          s_arsize,
  input  logic [S_COUNT*2-1:0]          s_arburst,
  input  logic [S_COUNT*4-1:0]          s_arqos,
  input  logic [S_COUNT-1:0]            s_arvalid,
  output logic [S_COUNT-1:0]            s_arready,
  output logic [S_COUNT*S_ID_WIDTH-1:0] s_rid,
  output logic [S_COUNT*DATA_WIDTH-1:0] s_rdata,
  output logic [S_COUNT*2-1:0]          s_rresp,
  output logic [S_COUNT-1:0]            s_rlast,
  output logic [S_COUNT-1:0]            s_rvalid,
  input  logic [S_COUNT-1:0]            s_rready,
  output logic [M_ID_WIDTH-1:0]         m_arid,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  output logic [3:0]                    m_arqos,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [M_ID_WIDTH-1:0]         m_rid,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  output logic                          err_bad_rid
);

  localparam int unsigned IdxW    = src_idx_w(S_COUNT);
  localparam int unsigned CntW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IdxSpan = 1 << IdxW;

  logic                  ar_full_q, ar_full_d;
  logic [M_ID_WIDTH-1:0] arid_q, arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  ar_ctrl_t              ctrl_q, ctrl_d;
  logic [CntW-1:0]       credit_q [S_COUNT];
  logic [CntW-1:0]       credit_d [S_COUNT];
  logic                  err_bad_rid_q, err_bad_rid_d;

  logic                  ar_load;
  logic [S_COUNT-1:0]    eligible;
  logic [S_COUNT-1:0]    gnt;
  logic [IdxW-1:0]       gnt_idx;
  logic                  gnt_valid;
  logic [S_COUNT-1:0]    cr_inc, cr_dec;
  logic [IdxW-1:0]       r_idx;
  logic                  r_bad;

  assign ar_load = !ar_full_q || m_arready;

  always_comb begin
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      eligible[i] = s_arvalid[i] && (credit_q[i] < CntW'(MAX_OUTSTANDING));
    end
  end

  hacd_rr_arbiter #(
    .N     (S_COUNT),
    .PrioW (4)
  ) u_rr_arbiter (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (eligible),
    .prio_i    (s_arqos),
    .advance_i (ar_load),
    .gnt_o     (gnt),
    .idx_o     (gnt_idx),
    .valid_o   (gnt_valid)
  );

  // Only a free (or draining) output stage may accept, so a held AR never changes.
  assign s_arready = ar_load ? gnt : '0;
  assign cr_inc    = s_arvalid & s_arready;

  always_comb begin
    ar_full_d = ar_full_q;
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    ctrl_d    = ctrl_q;
    if (ar_load) begin
      ar_full_d = gnt_valid;
      for (int unsigned i = 0; i < S_COUNT; i++) begin
        if (gnt[i]) begin
          arid_d       = M_ID_WIDTH'({gnt_idx, s_arid[i*S_ID_WIDTH +: S_ID_WIDTH]});
          araddr_d     = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          ctrl_d.len   = s_arlen[i*8 +: 8];
          ctrl_d.size  = s_arsize[i*3 +: 3];
          ctrl_d.burst = s_arburst[i*2 +: 2];
          ctrl_d.qos   = s_arqos[i*4 +: 4];
        end
      end
    end
  end

  assign m_arvalid = ar_full_q;
  assign m_arid    = arid_q;
  assign m_araddr  = araddr_q;
  assign m_arlen   = ctrl_q.len;
  assign m_arsize  = ctrl_q.size;
  assign m_arburst = ctrl_q.burst;
  assign m_arqos   = ctrl_q.qos;

  // R path: route by the source tag in the RID MSBs; unmapped tags are sunk and flagged.
  assign r_idx = m_rid[M_ID_WIDTH-1 -: IdxW];
  assign r_bad = (IdxSpan != S_COUNT) && (32'(r_idx) >= S_COUNT);

  always_comb begin
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      s_rvalid[i] = m_rvalid && !r_bad && (32'(r_idx) == i);
      cr_dec[i]   = s_rvalid[i] && s_rready[i] && m_rlast;
    end
  end

  assign m_rready = r_bad ? 1'b1 : s_rready[r_idx];
  assign s_rid    = {S_COUNT{m_rid[S_ID_WIDTH-1:0]}};
  assign s_rdata  = {S_COUNT{m_rdata}};
  assign s_rresp  = {S_COUNT{m_rresp}};
  assign s_rlast  = {S_COUNT{m_rlast}};

  assign err_bad_rid_d = err_bad_rid_q || (m_rvalid && r_bad);
  assign err_bad_rid   = err_bad_rid_q;

  always_comb begin
    for (int unsigned i = 0; i < S_COUNT; i++) begin
      credit_d[i] = credit_q[i];
      if (cr_inc[i] && !cr_dec[i]) begin
        credit_d[i] = credit_q[i] + 1'b1;
      end else if (!cr_inc[i] && cr_dec[i]) begin
        credit_d[i] = credit_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_full_q     <= 1'b0;
      arid_q        <= '0;
      araddr_q      <= '0;
      ctrl_q        <= '0;
      err_bad_rid_q <= 1'b0;
      for (int unsigned i = 0; i < S_COUNT; i++) begin
        credit_q[i] <= '0;
      end
    end else begin
      ar_full_q     <= ar_full_d;
      arid_q        <= arid_d;
      araddr_q      <= araddr_d;
      ctrl_q        <= ctrl_d;
      err_bad_rid_q <= err_bad_rid_d;
      for (int unsigned i = 0; i < S_COUNT; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

`ifndef SYNTHESIS
  for (genvar g = 0; g < S_COUNT; g++) begin : g_credit_chk
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(cr_inc[g] && !cr_dec[g] && (credit_q[g] == CntW'(MAX_OUTSTANDING))));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(cr_dec[g] && !cr_inc[g] && (credit_q[g] == '0)));
  end
`endif

endmodule

// File: tb/tb_hacd_axi_rd_arbiter.sv
// Bench for hacd_axi_rd_arbiter (2 sources): per-cycle reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_hacd_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_arid;
  logic [63:0] s_araddr;
  logic [15:0] s_arlen;
  logic [5:0]  s_arsize;
  logic [3:0]  s_arburst;
  logic [7:0]  s_arqos;
  logic [1:0]  s_arvalid, s_arready;
  logic [7:0]  s_rid;
  logic [127:0] s_rdata;
  logic [3:0]  s_rresp;
  logic [1:0]  s_rlast, s_rvalid, s_rready;
  logic [4:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [3:0]  m_arqos;
  logic        m_arvalid, m_arready;
  logic [4:0]  m_rid;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, m_rvalid, m_rready;
  logic        err_bad_rid;

  int tests = 0;
  int fails = 0;

  hacd_axi_rd_arbiter #(
    .S_COUNT         (2),
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (64),
    .S_ID_WIDTH      (4),
    .M_ID_WIDTH      (5),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_arid      (s_arid),
    .s_araddr    (s_araddr),
    .s_arlen     (s_arlen),
    .s_arsize    (s_arsize),
    .s_arburst   (s_arburst),
    .s_arqos     (s_arqos),
    .s_arvalid   (s_arvalid),
    .s_arready   (s_arready),
    .s_rid       (s_rid),
    .s_rdata     (s_rdata),
    .s_rresp     (s_rresp),
    .s_rlast     (s_rlast),
    .s_rvalid    (s_rvalid),
    .s_rready    (s_rready),
    .m_arid      (m_arid),
    .m_araddr    (m_araddr),
    .m_arlen     (m_arlen),
    .m_arsize    (m_arsize),
    .m_arburst   (m_arburst),
    .m_arqos     (m_arqos),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rid       (m_rid),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rlast     (m_rlast),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready),
    .err_bad_rid (err_bad_rid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an AR slot plus pointer and credit counts, advanced once per cycle.
  logic        mdl_full;
  logic [4:0]  mdl_id;
  logic [31:0] mdl_addr;
  logic [7:0]  mdl_len;
  logic [2:0]  mdl_size;
  logic [1:0]  mdl_burst;
  logic [3:0]  mdl_qos;
  int          mdl_ptr;
  int          mdl_cred [2];
  int          pick, best_q, ridx, src;
  logic        load;
  logic        exp_mrready;

  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_full = 1'b0; mdl_id = '0; mdl_addr = '0; mdl_len = '0;
      mdl_size = '0; mdl_burst = '0; mdl_qos = '0; mdl_ptr = 0;
      mdl_cred[0] = 0; mdl_cred[1] = 0;
    end else begin
      load   = !mdl_full || m_arready;
      pick   = -1;
      best_q = -1;
      if (load) begin
        for (int k = 0; k < 2; k++) begin
          src = (mdl_ptr + k) % 2;
          if (s_arvalid[src] && mdl_cred[src] < 8) begin
`ifdef HACD_RD_ARB_QOS_EN
            if (int'(s_arqos[src*4 +: 4]) > best_q) begin
              pick   = src;
              best_q = int'(s_arqos[src*4 +: 4]);
            end
`else
            if (pick < 0) pick = src;
`endif
          end
        end
      end
      ridx        = int'(m_rid[4]);
      exp_mrready = s_rready[ridx];

      chk("m_arvalid", 64'(m_arvalid), 64'(mdl_full));
      chk("m_arid", 64'(m_arid), 64'(mdl_id));
      chk("m_araddr", 64'(m_araddr), 64'(mdl_addr));
      chk("m_arlen", 64'(m_arlen), 64'(mdl_len));
      chk("m_arsize", 64'(m_arsize), 64'(mdl_size));
      chk("m_arburst", 64'(m_arburst), 64'(mdl_burst));
      chk("m_arqos", 64'(m_arqos), 64'(mdl_qos));
      chk("s_arready", 64'(s_arready), (pick >= 0) ? 64'(1) << pick : 64'(0));
      chk("s_rvalid", 64'(s_rvalid), m_rvalid ? 64'(1) << ridx : 64'(0));
      chk("m_rready", 64'(m_rready), 64'(exp_mrready));
      if (m_rvalid) begin
        chk("s_rid", 64'(s_rid[ridx*4 +: 4]), 64'(m_rid[3:0]));
        chk("s_rdata", s_rdata[ridx*64 +: 64], m_rdata);
        chk("s_rlast", 64'(s_rlast[ridx]), 64'(m_rlast));
      end
      chk("err_bad_rid", 64'(err_bad_rid), 64'(0));
      chk("credit0", 64'(dut.credit_q[0]), 64'(mdl_cred[0]));
      chk("credit1", 64'(dut.credit_q[1]), 64'(mdl_cred[1]));

      if (load) begin
        mdl_full = (pick >= 0);
        if (pick >= 0) begin
          mdl_id    = {pick[0], s_arid[pick*4 +: 4]};
          mdl_addr  = s_araddr[pick*32 +: 32];
          mdl_len   = s_arlen[pick*8 +: 8];
          mdl_size  = s_arsize[pick*3 +: 3];
          mdl_burst = s_arburst[pick*2 +: 2];
          mdl_qos   = s_arqos[pick*4 +: 4];
          mdl_ptr   = (pick + 1) % 2;
          mdl_cred[pick]++;
        end
      end
      if (m_rvalid && exp_mrready && m_rlast) mdl_cred[ridx]--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_src(input int i, input logic v, input logic [3:0] id,
                         input logic [31:0] addr, input logic [3:0] qos);
    s_arid[i*4 +: 4]    = id;
    s_araddr[i*32 +: 32] = addr;
    s_arlen[i*8 +: 8]   = 8'd3;
    s_arsize[i*3 +: 3]  = 3'd3;
    s_arburst[i*2 +: 2] = 2'b01;
    s_arqos[i*4 +: 4]   = qos;
    s_arvalid[i]        = v;
  endtask

  task automatic clear_inputs();
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_arqos = '0; s_arvalid = '0; s_rready = '0; m_arready = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [7:0] seq;
  int         acc0;

  initial begin
    clear_inputs();
    do_reset();

    // Reset state
    #1;
    chk("rst m_arvalid", 64'(m_arvalid), 64'(0));
    chk("rst s_arready", 64'(s_arready), 64'(0));
    chk("rst m_arid", 64'(m_arid), 64'(0));
    chk("rst err", 64'(err_bad_rid), 64'(0));

    // Single source 0 round trip
    set_src(0, 1'b1, 4'h3, 32'h100, 4'h0);
    m_arready = 1'b1;
    #1 chk("s1 s_arready", 64'(s_arready), 64'h1);
    tick();
    s_arvalid = '0;
    #1;
    chk("s1 m_arvalid", 64'(m_arvalid), 64'h1);
    chk("s1 m_arid", 64'(m_arid), 64'h03);
    chk("s1 credit up", 64'(dut.credit_q[0]), 64'd1);
    tick();
    #1 chk("s1 m_arvalid drop", 64'(m_arvalid), 64'h0);
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rid = 5'h03; m_rdata = 64'hA0 + 64'(b);
      m_rlast = (b == 3); s_rready = 2'b01;
      #1;
      chk("s1 s_rvalid", 64'(s_rvalid), 64'h1);
      chk("s1 s_rid", 64'(s_rid[3:0]), 64'h3);
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("s1 credit down", 64'(dut.credit_q[0]), 64'd0);

    // Both sources continuously valid
    do_reset();
    set_src(0, 1'b1, 4'h1, 32'h1000, 4'h0);
    set_src(1, 1'b1, 4'h2, 32'h2000, 4'h0);
    m_arready = 1'b1;
    seq = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      #1;
      chk("s2 no bubble", 64'(m_arvalid), 64'h1);
      seq[c] = m_arid[4];
    end
    chk("s2 alternation", 64'(seq[5:0]), 64'b101010);
    s_arvalid = '0;

    // Held AR under backpressure
    do_reset();
    set_src(0, 1'b1, 4'h5, 32'h1000, 4'h0);
    set_src(1, 1'b1, 4'h6, 32'h2000, 4'h0);
    m_arready = 1'b1;
    #1 chk("s3 first grant", 64'(s_arready), 64'h1);
    tick();
    m_arready = 1'b0;
    #1;
    chk("s3 held arid", 64'(m_arid), 64'h05);
    chk("s3 held ready", 64'(s_arready), 64'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      chk("s3 stall valid", 64'(m_arvalid), 64'h1);
      chk("s3 stall arid", 64'(m_arid), 64'h05);
      chk("s3 stall addr", 64'(m_araddr), 64'h1000);
      chk("s3 stall ready", 64'(s_arready), 64'h0);
    end
    m_arready = 1'b1;
    #1 chk("s3 release grant", 64'(s_arready), 64'h2);
    tick();
    #1;
    chk("s3 next valid", 64'(m_arvalid), 64'h1);
    chk("s3 next arid", 64'(m_arid), 64'h16);
    chk("s3 next addr", 64'(m_araddr), 64'h2000);
    s_arvalid = '0;

    // Credit cap on source 0
    do_reset();
    set_src(0, 1'b1, 4'h7, 32'h3000, 4'h0);
    m_arready = 1'b1;
    acc0 = 0;
    for (int c = 0; c < 10; c++) begin
      #1 acc0 += int'(s_arready[0]);
      tick();
    end
    chk("s4 accepts", 64'(acc0), 64'd8);
    chk("s4 credit cap", 64'(dut.credit_q[0]), 64'd8);
    set_src(1, 1'b1, 4'h8, 32'h4000, 4'h0);
    for (int c = 0; c < 3; c++) begin
      #1 chk("s4 src1 only", 64'(s_arready), 64'h2);
      tick();
    end
    m_rvalid = 1'b1; m_rid = 5'h00; m_rlast = 1'b1; s_rready = 2'b11;
    #1 chk("s4 rlast cycle", 64'(s_arready), 64'h2);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("s4 reenabled", 64'(s_arready), 64'h1);
    s_arvalid = '0;

    // Same-cycle accept and rlast for source 1
    do_reset();
    set_src(1, 1'b1, 4'h9, 32'h5000, 4'h0);
    m_arready = 1'b1;
    repeat (4) tick();
    #1 chk("s5 credit 4", 64'(dut.credit_q[1]), 64'd4);
    m_rvalid = 1'b1; m_rid = 5'h10; m_rlast = 1'b1; s_rready = 2'b10;
    #1 chk("s5 accept", 64'(s_arready), 64'h2);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; s_arvalid = '0;
    #1 chk("s5 credit held", 64'(dut.credit_q[1]), 64'd4);

    // QoS: unequal priorities
    do_reset();
    set_src(0, 1'b1, 4'h1, 32'h6000, 4'd2);
    set_src(1, 1'b1, 4'h2, 32'h7000, 4'd9);
    m_arready = 1'b1;
    seq = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1 seq[c] = m_arid[4];
    end
`ifdef HACD_RD_ARB_QOS_EN
    chk("s6 qos wins", 64'(seq[2:0]), 64'b111);
    chk("s6 qos fwd", 64'(m_arqos), 64'd9);
`else
    chk("s6 qos ignored", 64'(seq[2:0]), 64'b010);
    chk("s6 qos fwd", 64'(m_arqos), 64'd2);
`endif
    s_arvalid = '0;

    // QoS: equal priorities alternate
    do_reset();
    set_src(0, 1'b1, 4'h1, 32'h6000, 4'd5);
    set_src(1, 1'b1, 4'h2, 32'h7000, 4'd5);
    m_arready = 1'b1;
    seq = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      #1 seq[c] = m_arid[4];
    end
    chk("s7 equal qos", 64'(seq[3:0]), 64'b1010);
    s_arvalid = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
